// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: FSM state encoding, bus width, opcodes.
package fetch_sequencer_pkg;

  localparam int unsigned DataW = 8;
  localparam int unsigned OpW   = 5;

  // Opcode lives in instr[7:3]; instr[2:0] selects the register.
  localparam logic [OpW-1:0] OpLi = 5'b00001;
  localparam logic [OpW-1:0] OpLd = 5'b00010;
  localparam logic [OpW-1:0] OpSt = 5'b00011;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFReq   = 2'd1,
    StDecode = 2'd2,
    StMReq   = 2'd3
  } state_e;

  function automatic logic is_mem_opcode(input logic [DataW-1:0] instr);
    return (instr[7:3] == OpLd) || (instr[7:3] == OpSt);
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter: wraps modulo 2**AddrW, async active-low reset to ResetPc.
module fetch_sequencer_pc_reg #(
  parameter int unsigned      AddrW   = 8,
  parameter logic [AddrW-1:0] ResetPc = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [AddrW-1:0] pc_o,
  output logic [AddrW-1:0] pc_inc_o
);

  logic [AddrW-1:0] pc_q, pc_d;

  always_comb begin
    pc_inc_o = pc_q + 1'b1;
    pc_d     = inc_i ? pc_inc_o : pc_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch / memory-access sequencer driving a single-port bus on behalf of the decoder.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DataW-1:0]  bus_wdata,
  input  logic [DataW-1:0]  bus_rdata,
  input  logic              bus_ack,
  output logic [DataW-1:0]  instr,
  output logic              fetch_source,
  input  logic              increment_pc,
  input  logic              is_mem_op,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DataW-1:0]  st_data,
  output logic [DataW-1:0]  ld_data,
  output logic              ld_valid,
  output logic [ADDR_W-1:0] pc
);

  state_e state_q, state_d;

  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DataW-1:0]  bus_wdata_q, bus_wdata_d;
  logic [DataW-1:0]  instr_q, instr_d;
  logic              fetch_source_q, fetch_source_d;
  logic [DataW-1:0]  ld_data_q, ld_data_d;
  logic              ld_valid_q, ld_valid_d;

  logic              pc_inc_en;
  logic [ADDR_W-1:0] pc_inc;

  fetch_sequencer_pc_reg #(
    .AddrW   (ADDR_W),
    .ResetPc (RESET_PC)
  ) u_pc_reg (
    .clk_i    (clk),
    .rst_ni   (reset),
    .inc_i    (pc_inc_en),
    .pc_o     (pc),
    .pc_inc_o (pc_inc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (run) state_d = StFReq;
      StFReq:   if (bus_ack) state_d = StDecode;
      StDecode: begin
        if (is_mem_op)  state_d = StMReq;
        else if (run)   state_d = StFReq;
        else            state_d = StIdle;
      end
      StMReq:   if (bus_ack) state_d = run ? StFReq : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    instr_d        = instr_q;
    fetch_source_d = 1'b0;
    ld_data_d      = ld_data_q;
    ld_valid_d     = 1'b0;
    pc_inc_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = pc;
        end
      end
      StFReq: begin
        if (bus_ack) begin
          instr_d        = bus_rdata;
          bus_req_d      = 1'b0;
          fetch_source_d = 1'b1;
        end
      end
      StDecode: begin
        pc_inc_en = increment_pc;
        if (is_mem_op) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_rw;
          bus_addr_d  = mem_addr;
          bus_wdata_d = st_data;
        end else if (run) begin
          // Next fetch targets the post-increment PC, which only lands in pc next cycle.
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = increment_pc ? pc_inc : pc;
        end
      end
      StMReq: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            ld_data_d  = bus_rdata;
            ld_valid_d = 1'b1;
          end
          if (run) begin
            bus_req_d  = 1'b1;
            bus_we_d   = 1'b0;
            bus_addr_d = pc;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      instr_q        <= '0;
      fetch_source_q <= 1'b0;
      ld_data_q      <= '0;
      ld_valid_q     <= 1'b0;
    end else begin
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      instr_q        <= instr_d;
      fetch_source_q <= fetch_source_d;
      ld_data_q      <= ld_data_d;
      ld_valid_q     <= ld_valid_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign instr        = instr_q;
  assign fetch_source = fetch_source_q;
  assign ld_data      = ld_data_q;
  assign ld_valid     = ld_valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: bus and decoder are driven cycle by cycle from tasks.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic       clk;
  logic       reset;
  logic       run;
  logic       bus_req;
  logic       bus_we;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic [7:0] instr;
  logic       fetch_source;
  logic       increment_pc;
  logic       is_mem_op;
  logic       mem_rw;
  logic [7:0] mem_addr;
  logic [7:0] st_data;
  logic [7:0] ld_data;
  logic       ld_valid;
  logic [7:0] pc;

  int checks;
  int failures;

  fetch_sequencer #(
    .ADDR_W   (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .instr        (instr),
    .fetch_source (fetch_source),
    .increment_pc (increment_pc),
    .is_mem_op    (is_mem_op),
    .mem_rw       (mem_rw),
    .mem_addr     (mem_addr),
    .st_data      (st_data),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .pc           (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decoder model: every instruction advances the PC; LD/ST need a data access.
  task automatic decode(input logic [7:0] ins, input logic [7:0] addr, input logic [7:0] sd);
    increment_pc = 1'b1;
    is_mem_op    = is_mem_opcode(ins);
    mem_rw       = (ins[7:3] == OpSt);
    mem_addr     = addr;
    st_data      = sd;
  endtask

  task automatic test_reset();
    logic [44:0] all_out;
    repeat (2) @(posedge clk);
    #1;
    all_out = {bus_req, bus_we, bus_addr, bus_wdata, instr, fetch_source, ld_data, ld_valid, pc};
    checks++;
    if (all_out !== 45'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
  endtask

  task automatic test_li();
    reset = 1'b1;
    run   = 1'b1;
    tick();
    checks++;
    if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL li_first_req: got req=%b we=%b addr=%h expected 1 0 00", bus_req, bus_we,
               bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 8'h0F;
    tick();
    checks++;
    if ({fetch_source, instr, bus_req, ld_valid} !== {1'b1, 8'h0F, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL li_decode: got fs=%b instr=%h req=%b ldv=%b expected 1 0f 0 0",
               fetch_source, instr, bus_req, ld_valid);
    end
    bus_ack = 1'b0;
    decode(instr, 8'h00, 8'h00);
    tick();
    checks++;
    if ({bus_req, bus_addr, fetch_source, pc} !== {1'b1, 8'h01, 1'b0, 8'h01}) begin
      failures++;
      $display("FAIL li_next_fetch: got req=%b addr=%h fs=%b pc=%h expected 1 01 0 01",
               bus_req, bus_addr, fetch_source, pc);
    end
  endtask

  task automatic test_load();
    bus_ack = 1'b1; bus_rdata = 8'h12;
    tick();
    bus_ack = 1'b0;
    decode(8'h12, 8'h40, 8'h00);
    tick();
    checks++;
    if ({bus_req, bus_we, bus_addr, pc, fetch_source} !== {1'b1, 1'b0, 8'h40, 8'h02, 1'b0}) begin
      failures++;
      $display("FAIL ld_mreq: got req=%b we=%b addr=%h pc=%h fs=%b expected 1 0 40 02 0",
               bus_req, bus_we, bus_addr, pc, fetch_source);
    end
    bus_ack = 1'b1; bus_rdata = 8'hA5;
    is_mem_op = 1'b0; increment_pc = 1'b0;
    tick();
    checks++;
    if ({ld_valid, ld_data, bus_req, bus_we, bus_addr, fetch_source} !==
        {1'b1, 8'hA5, 1'b1, 1'b0, 8'h02, 1'b0}) begin
      failures++;
      $display("FAIL ld_complete: got ldv=%b ld=%h req=%b we=%b addr=%h fs=%b expected 1 a5 1 0 02 0",
               ld_valid, ld_data, bus_req, bus_we, bus_addr, fetch_source);
    end
    bus_ack = 1'b0;
    tick();
    checks++;
    if ({ld_valid, ld_data, bus_req} !== {1'b0, 8'hA5, 1'b1}) begin
      failures++;
      $display("FAIL ld_pulse: got ldv=%b ld=%h req=%b expected 0 a5 1", ld_valid, ld_data,
               bus_req);
    end
  endtask

  task automatic test_store();
    bus_ack = 1'b1; bus_rdata = 8'h1B;
    tick();
    bus_ack = 1'b0;
    decode(8'h1B, 8'h80, 8'h3C);
    tick();
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata} !== {1'b1, 1'b1, 8'h80, 8'h3C}) begin
      failures++;
      $display("FAIL st_mreq: got req=%b we=%b addr=%h wd=%h expected 1 1 80 3c", bus_req, bus_we,
               bus_addr, bus_wdata);
    end
    // Decoder-side operands change while the bus waits; the request must not follow them.
    mem_addr = 8'h11; st_data = 8'h77; is_mem_op = 1'b0; increment_pc = 1'b0; mem_rw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_wdata, ld_valid} !==
          {1'b1, 1'b1, 8'h80, 8'h3C, 1'b0}) begin
        failures++;
        $display("FAIL st_wait%0d: got req=%b we=%b addr=%h wd=%h ldv=%b expected 1 1 80 3c 0", i,
                 bus_req, bus_we, bus_addr, bus_wdata, ld_valid);
      end
    end
    bus_ack = 1'b1;
    tick();
    checks++;
    if ({ld_valid, ld_data, bus_req, bus_we, bus_addr} !== {1'b0, 8'hA5, 1'b1, 1'b0, 8'h03}) begin
      failures++;
      $display("FAIL st_complete: got ldv=%b ld=%h req=%b we=%b addr=%h expected 0 a5 1 0 03",
               ld_valid, ld_data, bus_req, bus_we, bus_addr);
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_pc_wrap();
    for (int i = 0; i < 252; i++) begin
      bus_ack = 1'b1; bus_rdata = 8'h0F;
      tick();
      bus_ack = 1'b0;
      decode(8'h0F, 8'h00, 8'h00);
      tick();
    end
    checks++;
    if ({pc, bus_addr, bus_req} !== {8'hFF, 8'hFF, 1'b1}) begin
      failures++;
      $display("FAIL wrap_at_ff: got pc=%h addr=%h req=%b expected ff ff 1", pc, bus_addr, bus_req);
    end
    bus_ack = 1'b1; bus_rdata = 8'h0F;
    tick();
    bus_ack = 1'b0;
    decode(8'h0F, 8'h00, 8'h00);
    tick();
    checks++;
    if ({pc, bus_addr, bus_req} !== {8'h00, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL wrap_to_00: got pc=%h addr=%h req=%b expected 00 00 1", pc, bus_addr, bus_req);
    end
  endtask

  task automatic test_idle_spurious();
    bus_ack = 1'b1; bus_rdata = 8'h0F;
    tick();
    bus_ack = 1'b0;
    decode(8'h0F, 8'h00, 8'h00);
    run = 1'b0;
    tick();
    checks++;
    if ({bus_req, pc, fetch_source} !== {1'b0, 8'h01, 1'b0}) begin
      failures++;
      $display("FAIL idle_park: got req=%b pc=%h fs=%b expected 0 01 0", bus_req, pc, fetch_source);
    end
    increment_pc = 1'b0;
    bus_ack = 1'b1; bus_rdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus_req, fetch_source, ld_valid, instr, ld_data, pc} !==
          {1'b0, 1'b0, 1'b0, 8'h0F, 8'hA5, 8'h01}) begin
        failures++;
        $display("FAIL idle_spurious%0d: got req=%b fs=%b ldv=%b instr=%h ld=%h pc=%h expected 0 0 0 0f a5 01",
                 i, bus_req, fetch_source, ld_valid, instr, ld_data, pc);
      end
    end
    bus_ack = 1'b0;
    run = 1'b1;
    tick();
    checks++;
    if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b0, 8'h01}) begin
      failures++;
      $display("FAIL idle_resume: got req=%b we=%b addr=%h expected 1 0 01", bus_req, bus_we,
               bus_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic [44:0] all_out;
    bus_ack = 1'b1; bus_rdata = 8'h12;
    tick();
    bus_ack = 1'b0;
    decode(8'h12, 8'h55, 8'h00);
    tick();
    checks++;
    if ({bus_req, bus_addr} !== {1'b1, 8'h55}) begin
      failures++;
      $display("FAIL rst_mreq: got req=%b addr=%h expected 1 55", bus_req, bus_addr);
    end
    is_mem_op = 1'b0; increment_pc = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    all_out = {bus_req, bus_we, bus_addr, bus_wdata, instr, fetch_source, ld_data, ld_valid, pc};
    checks++;
    if (all_out !== 45'd0) begin
      failures++;
      $display("FAIL rst_async: got %h expected 0", all_out);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    run   = 1'b1;
    tick();
    checks++;
    if ({bus_req, bus_we, bus_addr, pc} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL rst_restart: got req=%b we=%b addr=%h pc=%h expected 1 0 00 00", bus_req,
               bus_we, bus_addr, pc);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    run          = 1'b0;
    bus_ack      = 1'b0;
    bus_rdata    = 8'h00;
    increment_pc = 1'b0;
    is_mem_op    = 1'b0;
    mem_rw       = 1'b0;
    mem_addr     = 8'h00;
    st_data      = 8'h00;
    test_reset();
    test_li();
    test_load();
    test_store();
    test_pc_wrap();
    test_idle_spurious();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
